activity_trigger_gen: RTL

//   Upstream stage of the front-panel LED blinker. Turns an asynchronous activity

---
 rtl/activity_trigger_gen_pkg.sv | 28 ++
 rtl/activity_trigger_gen_if.sv | 22 ++
 rtl/activity_trigger_gen_sync_edge_detect.sv | 55 +++++
 rtl/activity_trigger_gen.sv | 105 ++++++++++
 4 files changed

// File: rtl/activity_trigger_gen_pkg.sv
// Shared definitions for the activity trigger generator: FSM state encoding,
// edge-mode codes and small arithmetic helpers used by the top level.
package activity_trigger_gen_pkg;

  // FSM states: ARMED accepts events, HOLDOFF rate-limits after a trigger.
  typedef enum logic {
    ST_ARMED   = 1'b0,
    ST_HOLDOFF = 1'b1
  } state_t;

  // Which transitions of the synchronised input count as events.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  // A prescale of zero behaves as one: every qualifying event fires.
  function automatic logic [15:0] eff_prescale(input logic [15:0] prescale);
    return (prescale == 16'd0) ? 16'd1 : prescale;
  endfunction

  // Saturating increment for the drop counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == DROP_MAX) ? DROP_MAX : value + 16'd1;
  endfunction

endpackage

// File: rtl/activity_trigger_gen_if.sv
// Status/control bundle of the activity trigger generator. The master side
// drives the activity input and controls; the slave side (the generator)
// returns the trigger pulse and status counters.
interface activity_trigger_gen_if;
  logic        async_in;
  logic        enable;
  logic [15:0] prescale;
  logic        trigger;
  logic [31:0] event_count;
  logic [15:0] drop_count;
  logic        armed;

  modport master (
    output async_in, enable, prescale,
    input  trigger, event_count, drop_count, armed
  );

  modport slave (
    input  async_in, enable, prescale,
    output trigger, event_count, drop_count, armed
  );
endinterface

// File: rtl/activity_trigger_gen_sync_edge_detect.sv
// Synchroniser chain for the asynchronous activity input, one delay flop
// holding the previous synchronised level, and a registered edge detector.
// SYNC_STAGES is meant to be 2..4. Edges are masked until the chain and the
// delay flop hold real samples, so a level present at reset release is never
// mistaken for an edge.
module sync_edge_detect
  import activity_trigger_gen_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic edge_det
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
  (* ASYNC_REG = "TRUE" *) logic                   level_q;
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES:0]   warm_q;
  (* ASYNC_REG = "TRUE" *) logic                   edge_q;

  logic sync_lvl;
  logic hit;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Select which transition of the synchronised level is an event.
  always_comb begin
    hit = 1'b0;
    if (EDGE_MODE == EDGE_RISE)      hit = sync_lvl & ~level_q;
    else if (EDGE_MODE == EDGE_FALL) hit = ~sync_lvl & level_q;
    else                             hit = sync_lvl ^ level_q;
  end

  // Shift the input through the synchroniser and register the edge pulse.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      warm_q  <= '0;
      edge_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      level_q <= sync_lvl;
      warm_q  <= {warm_q[SYNC_STAGES-1:0], 1'b1};
      edge_q  <= warm_q[SYNC_STAGES] & hit;
    end
  end

  assign edge_det = edge_q;

endmodule

// File: rtl/activity_trigger_gen.sv
// Activity trigger generator: turns a synchronised activity edge stream into
// rate-limited single-cycle trigger pulses. Events are prescaled in ARMED;
// after each trigger a holdoff window of HOLDOFF clocks drops further events.
module activity_trigger_gen
  import activity_trigger_gen_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter int          EDGE_MODE   = EDGE_RISE,
  parameter logic [31:0] HOLDOFF     = 32'd1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  activity_trigger_gen_if.slave bus
);

  logic        edge_det;

  state_t      state_q, state_d;
  logic [15:0] pre_q, pre_d;
  logic [31:0] hold_q, hold_d;
  logic        trig_q, trig_d;
  logic [31:0] event_q;
  logic [15:0] drop_q;
  logic [15:0] eff_pre;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_MODE   (EDGE_MODE)
  ) u_sync_edge_detect (
    .clk      (clk),
    .reset    (reset),
    .async_in (bus.async_in),
    .edge_det (edge_det)
  );

  // Prescale is compared live so a lowered value takes effect immediately.
  assign eff_pre = eff_prescale(bus.prescale);

  // Next-state, prescale/holdoff counter updates and the trigger request.
  // NOTE: every variable gets a default before any branch, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    hold_d  = hold_q;
    trig_d  = 1'b0;
    case (state_q)
      ST_ARMED: begin
        if (!bus.enable) begin
          pre_d = 16'd0;
        end else if (edge_det) begin
          if (pre_q >= eff_pre - 16'd1) begin
            trig_d = 1'b1;
            pre_d  = 16'd0;
            if (HOLDOFF != 32'd0) begin
              hold_d  = HOLDOFF - 32'd1;
              state_d = ST_HOLDOFF;
            end
          end else begin
            pre_d = pre_q + 16'd1;
          end
        end
      end
      ST_HOLDOFF: begin
        // Events here are dropped; the prescale count does not advance.
        if (!bus.enable) pre_d = 16'd0;
        if (hold_q == 32'd0) state_d = ST_ARMED;
        else                 hold_d  = hold_q - 32'd1;
      end
      default: state_d = ST_ARMED;
    endcase
  end

  // FSM state, prescale/holdoff counters and the registered trigger.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ARMED;
      pre_q   <= 16'd0;
      hold_q  <= 32'd0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      hold_q  <= hold_d;
      trig_q  <= trig_d;
    end
  end

  // Status counters: all edges, and edges dropped by the holdoff window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_q <= 32'd0;
      drop_q  <= 16'd0;
    end else if (edge_det) begin
      event_q <= event_q + 32'd1;
      if (state_q == ST_HOLDOFF) drop_q <= sat_inc16(drop_q);
    end
  end

  assign bus.trigger     = trig_q;
  assign bus.event_count = event_q;
  assign bus.drop_count  = drop_q;
  assign bus.armed       = (state_q == ST_ARMED);

endmodule
